// File: rtl/accum_pkg.sv
// Shared types for the multi-lane accumulator: opcode and controller state.
package accum_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } accum_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } accum_state_e;

endpackage

// File: rtl/accum_lane.sv
// One accumulator lane: arithmetic on the update strobe, optional clamping,
// and a sticky over/underflow flag.
module accum_lane
    import accum_pkg::*;
#(
    parameter int ACCUM_WIDTH = 32,
    parameter int ADD_WIDTH   = 16,
    parameter int SATURATE    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   upd,
    input  accum_op_e              op,
    input  logic                   en,
    input  logic [ADD_WIDTH-1:0]   operand,
    input  logic                   clr_ovf,
    output logic [ACCUM_WIDTH-1:0] accum,
    output logic                   ovf
);

    logic [ACCUM_WIDTH-1:0] acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [ACCUM_WIDTH-1:0] ext;
    logic [ACCUM_WIDTH:0]   sum, diff;
    logic                   set;

    assign ext  = ACCUM_WIDTH'(operand);
    assign sum  = {1'b0, acc_q} + {1'b0, ext};
    assign diff = {1'b0, acc_q} - {1'b0, ext};

    always_comb begin
        acc_d = acc_q;
        set   = 1'b0;
        if (upd && en) begin
            case (op)
                OP_ADD: begin
                    acc_d = sum[ACCUM_WIDTH-1:0];
                    if (sum[ACCUM_WIDTH]) begin
                        set = 1'b1;
                        if (SATURATE != 0) acc_d = '1;
                    end
                end
                OP_SUB: begin
                    acc_d = diff[ACCUM_WIDTH-1:0];
                    if (diff[ACCUM_WIDTH]) begin
                        set = 1'b1;
                        if (SATURATE != 0) acc_d = '0;
                    end
                end
                OP_LOAD:  acc_d = ext;
                OP_CLEAR: acc_d = '0;
                default:  acc_d = acc_q;
            endcase
        end
        // A fresh overflow on this edge beats a simultaneous clear.
        ovf_d = set | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign accum = acc_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/accum_multi.sv
// Multi-lane accumulator: request capture, IDLE/EXEC/DONE controller,
// completed-op counter, and one accum_lane per lane.
module accum_multi
    import accum_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int ACCUM_WIDTH = 32,
    parameter int ADD_WIDTH   = 16,
    parameter int SATURATE    = 0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  accum_op_e                           op,
    input  logic [LANES-1:0]                    lane_en,
    input  logic [LANES-1:0][ADD_WIDTH-1:0]     add,
    output logic [LANES-1:0][ACCUM_WIDTH-1:0]   accum,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES-1:0]                    ovf,
    input  logic                                clr_ovf,
    output logic [COUNT_WIDTH-1:0]              op_count,
    output accum_state_e                        dbg_state
);

    if (ADD_WIDTH > ACCUM_WIDTH) begin : g_width_check
        $error("accum_multi: ADD_WIDTH must not exceed ACCUM_WIDTH");
    end

    // Handshakes: a request transfers on a clock edge where in_valid && in_ready;
    // a response transfers on an edge where out_valid && out_ready. out_valid
    // stays high until that transfer; in_ready is high only in IDLE.
    accum_state_e                  state_q, state_d;
    logic                          in_ready_q;
    logic [COUNT_WIDTH-1:0]        op_count_q;
    accum_op_e                     op_q;
    logic [LANES-1:0]              lane_en_q;
    logic [LANES-1:0][ADD_WIDTH-1:0] add_q;
    logic                          capture;
    logic                          upd;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        upd     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    capture = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                upd     = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is registered so it stays low for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == IDLE);
            if (upd) op_count_q <= op_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            op_q      <= op;
            lane_en_q <= lane_en;
            add_q     <= add;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        accum_lane #(
            .ACCUM_WIDTH (ACCUM_WIDTH),
            .ADD_WIDTH   (ADD_WIDTH),
            .SATURATE    (SATURATE)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .upd     (upd),
            .op      (op_q),
            .en      (lane_en_q[i]),
            .operand (add_q[i]),
            .clr_ovf (clr_ovf),
            .accum   (accum[i]),
            .ovf     (ovf[i])
        );
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign op_count  = op_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_accum_multi.sv
// Directed + random bench: a wrapping and a saturating instance share stimulus
// and are compared against an arithmetic reference model.
module tb_accum_multi;
    import accum_pkg::*;

    localparam int LANES = 4;
    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int CW    = 5;
    localparam longint MAXV = (longint'(1) << AW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    accum_op_e op;
    logic [LANES-1:0] lane_en;
    logic [LANES-1:0][DW-1:0] add;
    logic out_ready;
    logic clr_ovf;

    logic in_ready_w, in_ready_s, out_valid_w, out_valid_s;
    logic [LANES-1:0][AW-1:0] acc_w, acc_s;
    logic [LANES-1:0] ovf_w, ovf_s;
    logic [CW-1:0] cnt_w, cnt_s;
    accum_state_e st_w, st_s;

    always #5 clk = ~clk;

    accum_multi #(.LANES(LANES), .ACCUM_WIDTH(AW), .ADD_WIDTH(DW), .SATURATE(0), .COUNT_WIDTH(CW)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w), .op(op),
        .lane_en(lane_en), .add(add), .accum(acc_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .ovf(ovf_w), .clr_ovf(clr_ovf), .op_count(cnt_w), .dbg_state(st_w)
    );

    accum_multi #(.LANES(LANES), .ACCUM_WIDTH(AW), .ADD_WIDTH(DW), .SATURATE(1), .COUNT_WIDTH(CW)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .op(op),
        .lane_en(lane_en), .add(add), .accum(acc_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .ovf(ovf_s), .clr_ovf(clr_ovf), .op_count(cnt_s), .dbg_state(st_s)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: index 0 = wrapping instance, 1 = saturating instance.
    longint m_acc [2][LANES];
    logic [LANES-1:0] m_ovf [2];
    int m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < LANES; i++) m_acc[s][i] = 0;
            m_ovf[s] = '0;
        end
        m_cnt = 0;
    endtask

    task automatic model_apply(input accum_op_e o, input logic [LANES-1:0] en,
                               input logic [LANES-1:0][DW-1:0] a, input bit clr);
        for (int s = 0; s < 2; s++) begin
            logic [LANES-1:0] set = '0;
            for (int i = 0; i < LANES; i++) begin
                longint v = longint'(a[i]);
                if (en[i]) begin
                    case (o)
                        OP_ADD: begin
                            if (m_acc[s][i] + v > MAXV) begin
                                set[i] = 1'b1;
                                m_acc[s][i] = (s == 1) ? MAXV : m_acc[s][i] + v - (MAXV + 1);
                            end else m_acc[s][i] = m_acc[s][i] + v;
                        end
                        OP_SUB: begin
                            if (v > m_acc[s][i]) begin
                                set[i] = 1'b1;
                                m_acc[s][i] = (s == 1) ? 0 : m_acc[s][i] + (MAXV + 1) - v;
                            end else m_acc[s][i] = m_acc[s][i] - v;
                        end
                        OP_LOAD:  m_acc[s][i] = v;
                        default:  m_acc[s][i] = 0;
                    endcase
                end
            end
            m_ovf[s] = set | (clr ? '0 : m_ovf[s]);
        end
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("%s wrap acc%0d", tag, i), 64'(acc_w[i]), 64'(m_acc[0][i]));
            chk($sformatf("%s sat acc%0d", tag, i), 64'(acc_s[i]), 64'(m_acc[1][i]));
        end
        chk({tag, " wrap ovf"}, 64'(ovf_w), 64'(m_ovf[0]));
        chk({tag, " sat ovf"}, 64'(ovf_s), 64'(m_ovf[1]));
        chk({tag, " wrap op_count"}, 64'(cnt_w), 64'(m_cnt));
        chk({tag, " sat op_count"}, 64'(cnt_s), 64'(m_cnt));
    endtask

    task automatic scramble_inputs();
        op      = accum_op_e'($urandom_range(0, 3));
        lane_en = LANES'($urandom_range(0, (1 << LANES) - 1));
        for (int i = 0; i < LANES; i++) add[i] = DW'($urandom_range(0, (1 << DW) - 1));
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!(in_ready_w === 1'b1 && in_ready_s === 1'b1) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " in_ready wait"}, 64'({in_ready_w, in_ready_s}), 64'(2'b11));
    endtask

    // Called and returns on a negedge. hold = extra cycles out_ready is held low.
    task automatic do_op(input string tag, input accum_op_e o, input logic [LANES-1:0] en,
                         input logic [LANES-1:0][DW-1:0] a, input bit clr, input int hold);
        wait_ready(tag);
        in_valid = 1'b1; op = o; lane_en = en; add = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        clr_ovf = clr;
        @(negedge clk);
        chk({tag, " out_valid in EXEC"}, 64'({out_valid_w, out_valid_s}), 64'(2'b00));
        chk({tag, " in_ready in EXEC"}, 64'({in_ready_w, in_ready_s}), 64'(2'b00));
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        model_apply(o, en, a, clr);
        @(negedge clk);
        if (hold > 0) out_ready = 1'b0;
        chk({tag, " out_valid"}, 64'({out_valid_w, out_valid_s}), 64'(2'b11));
        check_all(tag);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk($sformatf("%s held out_valid %0d", tag, k), 64'({out_valid_w, out_valid_s}), 64'(2'b11));
            chk($sformatf("%s held in_ready %0d", tag, k), 64'({in_ready_w, in_ready_s}), 64'(2'b00));
        end
        out_ready = 1'b1;
    endtask

    task automatic pulse_clr(input string tag);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        m_ovf[0] = '0;
        m_ovf[1] = '0;
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [LANES-1:0][DW-1:0] a;
        logic [AW-1:0] keep1, keep3;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
        op = OP_ADD; lane_en = '0; add = '0;
        model_reset();

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all("reset");
        chk("reset out_valid", 64'({out_valid_w, out_valid_s}), 64'(2'b00));
        chk("reset in_ready low", 64'({in_ready_w, in_ready_s}), 64'(2'b00));
        @(negedge clk);
        chk("reset in_ready after release", 64'({in_ready_w, in_ready_s}), 64'(2'b11));

        // ADD {1,2,3,4} twice on all lanes.
        a[0] = 16'd1; a[1] = 16'd2; a[2] = 16'd3; a[3] = 16'd4;
        do_op("add1", OP_ADD, 4'hF, a, 1'b0, 0);
        do_op("add2", OP_ADD, 4'hF, a, 1'b0, 0);
        chk("add2 lane0 const", 64'(acc_w[0]), 64'd2);
        chk("add2 lane3 const", 64'(acc_w[3]), 64'd8);

        // LOAD 0xFFFF then ADD 0xFFFF until past full scale.
        for (int i = 0; i < LANES; i++) a[i] = 16'hFFFF;
        do_op("load_ffff", OP_LOAD, 4'hF, a, 1'b0, 0);
        for (int n = 0; n < 17; n++) do_op($sformatf("add_ffff%0d", n), OP_ADD, 4'hF, a, 1'b0, 0);
        chk("sat clamp const", 64'(acc_s[0]), 64'(MAXV));
        chk("sat ovf const", 64'(ovf_s), 64'(4'hF));

        // SUB underflow with clr_ovf on the same edge: set wins on lanes 0,1, lanes 2,3 clear.
        a[0] = 16'd5; a[1] = 16'd5; a[2] = 16'd9; a[3] = 16'd9;
        do_op("load5", OP_LOAD, 4'hF, a, 1'b0, 0);
        for (int i = 0; i < LANES; i++) a[i] = 16'd7;
        do_op("sub7", OP_SUB, 4'hF, a, 1'b1, 0);
        chk("sub7 wrap const", 64'(acc_w[0]), 64'(MAXV - 1));
        chk("sub7 sat const", 64'(acc_s[0]), 64'd0);
        chk("sub7 ovf const", 64'(ovf_w), 64'(4'b0011));
        pulse_clr("clr_idle");

        // Lane mask 0101 with five cycles of backpressure.
        keep1 = acc_w[1];
        keep3 = acc_w[3];
        for (int i = 0; i < LANES; i++) a[i] = 16'd10;
        do_op("mask", OP_ADD, 4'b0101, a, 1'b0, 5);
        chk("mask lane1 held", 64'(acc_w[1]), 64'(keep1));
        chk("mask lane3 held", 64'(acc_w[3]), 64'(keep3));

        // Reset while the op is in EXEC.
        wait_ready("rst_mid");
        in_valid = 1'b1; op = OP_LOAD; lane_en = 4'hF;
        for (int i = 0; i < LANES; i++) add[i] = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("rst_mid");
        chk("rst_mid out_valid", 64'({out_valid_w, out_valid_s}), 64'(2'b00));
        chk("rst_mid in_ready low", 64'({in_ready_w, in_ready_s}), 64'(2'b00));
        @(negedge clk);
        chk("rst_mid in_ready", 64'({in_ready_w, in_ready_s}), 64'(2'b11));
        a[0] = 16'd3; a[1] = 16'd0; a[2] = 16'hFFFF; a[3] = 16'd100;
        do_op("after_rst", OP_ADD, 4'hF, a, 1'b0, 0);

        // Random ops; enough of them to wrap the op counter.
        for (int n = 0; n < 40; n++) begin
            accum_op_e ro;
            logic [LANES-1:0] re;
            ro = accum_op_e'($urandom_range(0, 3));
            re = LANES'($urandom_range(0, (1 << LANES) - 1));
            for (int i = 0; i < LANES; i++) a[i] = DW'($urandom_range(0, (1 << DW) - 1));
            do_op($sformatf("rand%0d", n), ro, re, a, ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
